// File: rtl/query_patch_mem_wb.sv
// Query patch memory: DEPTH rows of one patch each, accelerator 1RW + 1R ports,
// and a Wishbone classic slave that reads/writes the rows in 32-bit chunks.
module query_patch_mem_wb #(
  parameter int          DATA_WIDTH = 11,
  parameter int          PATCH_SIZE = 5,
  parameter int          DEPTH      = 512,
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] WB_BASE    = 32'h3000_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wb_mode,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch0,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rpatch1,
  input  logic                             wbs_stb_i,
  input  logic                             wbs_cyc_i,
  input  logic                             wbs_we_i,
  input  logic [3:0]                       wbs_sel_i,
  input  logic [31:0]                      wbs_dat_i,
  input  logic [31:0]                      wbs_adr_i,
  output logic                             wbs_ack_o,
  output logic [31:0]                      wbs_dat_o
);
  localparam int PATCH_W    = DATA_WIDTH * PATCH_SIZE;
  localparam int CHUNKS     = (PATCH_W + 31) / 32;
  localparam int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int ROW_W      = CHUNKS * 32;
  localparam int ROW_BYTES  = CHUNKS * 4;
  localparam logic [31:0]      WA_LIMIT   = 32'(DEPTH) << CHUNK_BITS;
  localparam logic [ROW_W-1:0] PATCH_MASK = ROW_W'({PATCH_W{1'b1}});

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
  state_t state, state_nxt;

  logic [ROW_W-1:0]      mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_row;
  logic [ROW_W-1:0]      mem_wdata;
  logic [ROW_BYTES-1:0]  mem_be;

  logic [31:0]           wb_off, wb_wa;
  logic [CHUNK_BITS-1:0] wb_chunk;
  logic [ADDR_WIDTH-1:0] wb_row;
  logic                  wb_hit, wb_req;
  logic [ROW_W-1:0]      wb_row_data;
  logic [31:0]           wb_rd_word, wb_rd_q;

  assign wb_off   = wbs_adr_i - WB_BASE;
  assign wb_wa    = wb_off >> 2;
  assign wb_chunk = wb_wa[CHUNK_BITS-1:0];
  assign wb_row   = wb_wa[CHUNK_BITS+ADDR_WIDTH-1:CHUNK_BITS];
  assign wb_hit   = (wbs_adr_i >= WB_BASE) && (wb_wa < WA_LIMIT);
  assign wb_req   = wb_mode && wbs_cyc_i && wbs_stb_i && wb_hit;

  // Wishbone handshake: a request is taken only in IDLE with cyc&stb on a hit;
  // ack is high for exactly the one cycle the FSM sits in ACK, with read data
  // already valid on wbs_dat_o in that cycle. Misses are never acked.
  assign wbs_ack_o = (state == ACK);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_req) state_nxt = wbs_we_i ? ACK : RD_WAIT;
      RD_WAIT: state_nxt = (wbs_cyc_i && wb_mode) ? ACK : IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk indices past CHUNKS match no slot: the write enables nothing, the read gives 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_row   = addr0;
    mem_wdata = ROW_W'(wpatch0);
    mem_be    = '1;
    if (!wb_mode) begin
      mem_we = !csb0 && !web0;
    end else if (state == IDLE && wb_req && wbs_we_i) begin
      mem_we    = 1'b1;
      mem_row   = wb_row;
      mem_wdata = '0;
      mem_be    = '0;
      for (int c = 0; c < CHUNKS; c++) begin
        if (wb_chunk == CHUNK_BITS'(c)) begin
          mem_wdata[c*32 +: 32] = wbs_dat_i;
          mem_be[c*4 +: 4]      = wbs_sel_i;
        end
      end
    end
  end

  always_comb begin
    wb_row_data = mem[wb_row] & PATCH_MASK;
    wb_rd_word  = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (wb_chunk == CHUNK_BITS'(c)) wb_rd_word = wb_row_data[c*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < ROW_BYTES; b++) begin
        if (mem_be[b]) mem[mem_row][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Nonblocking reads see pre-write contents, giving old data on same-row collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpatch0   <= '0;
      rpatch1   <= '0;
      wb_rd_q   <= '0;
      wbs_dat_o <= '0;
    end else begin
      if (!wb_mode && !csb0 && web0) rpatch0 <= mem[addr0][PATCH_W-1:0];
      if (!csb1) rpatch1 <= mem[addr1][PATCH_W-1:0];
      if (state == IDLE && wb_req && !wbs_we_i) wb_rd_q <= wb_rd_word;
      if (state == RD_WAIT && wbs_cyc_i && wb_mode) wbs_dat_o <= wb_rd_q;
    end
  end
endmodule

// File: tb/tb_query_patch_mem_wb.sv
// Bench for query_patch_mem_wb: directed scenarios plus random traffic against
// a row/word-level memory model that predicts every output each cycle.
module tb_query_patch_mem_wb;
  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [63:0] M55   = 64'h007F_FFFF_FFFF_FFFF;
  localparam logic [54:0] ROW7  = 55'h12_3456_789A_BCDE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_mode = 1'b0;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [54:0] wpatch0 = '0;
  logic [54:0] rpatch0, rpatch1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  query_patch_mem_wb dut (
    .clk(clk), .rst_n(rst_n), .wb_mode(wb_mode),
    .csb0(csb0), .web0(web0), .addr0(addr0), .wpatch0(wpatch0), .rpatch0(rpatch0),
    .csb1(csb1), .addr1(addr1), .rpatch1(rpatch1),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mm [DEPTH];
  logic [54:0] exp_r0 = '0, exp_r1 = '0;
  logic [31:0] exp_dat = '0;
  logic        exp_ack = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;

  function automatic void model_step();
    logic [63:0] off;
    int row, chunk;
    bit hit;
    if (!wb_mode && !csb0 && web0) exp_r0 = 55'(mm[addr0]);
    if (!csb1) exp_r1 = 55'(mm[addr1]);
    off   = {32'b0, wbs_adr_i} - {32'b0, BASE};
    hit   = (wbs_adr_i >= BASE) && ((off >> 2) < 64'd1024);
    row   = int'(off >> 3);
    chunk = int'((off >> 2) & 64'd1);
    if (exp_ack) begin
      exp_ack = 1'b0;
    end else if (rd_pend) begin
      rd_pend = 1'b0;
      if (wbs_cyc_i && wb_mode) begin
        exp_dat = rd_data;
        exp_ack = 1'b1;
      end
    end else if (wb_mode && wbs_cyc_i && wbs_stb_i && hit) begin
      if (wbs_we_i) begin
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) mm[row][chunk*32 + b*8 +: 8] = wbs_dat_i[b*8 +: 8];
        exp_ack = 1'b1;
      end else begin
        rd_pend = 1'b1;
        rd_data = 32'((mm[row] & M55) >> (32 * chunk));
      end
    end
    if (!wb_mode && !csb0 && !web0) mm[addr0] = {9'b0, wpatch0};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_r0 = '0; exp_r1 = '0; exp_dat = '0; exp_ack = 1'b0; rd_pend = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && check_en) begin
        chk("cyc_ack", {63'b0, wbs_ack_o}, {63'b0, exp_ack});
        chk("cyc_rpatch0", {9'b0, rpatch0}, {9'b0, exp_r0});
        chk("cyc_rpatch1", {9'b0, rpatch1}, {9'b0, exp_r1});
        chk("cyc_wbs_dat_o", {32'b0, wbs_dat_o}, {32'b0, exp_dat});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic acc_cycle(input bit wr0, input bit rd0, input logic [8:0] a0,
                           input logic [54:0] d0, input bit rd1, input logic [8:0] a1);
    @(negedge clk);
    csb0 = !(wr0 || rd0); web0 = !wr0; addr0 = a0; wpatch0 = d0;
    csb1 = !rd1; addr1 = a1;
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat, output logic [31:0] rdat);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = -1; rdat = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        lat = i; rdat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_miss(input string name, input logic [31:0] adr);
    int acks = 0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = adr; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk(name, 64'(acks), 64'd0);
  endtask

  function automatic logic [31:0] rand_adr();
    int k = int'($urandom_range(0, 9));
    if (k == 0) return BASE - 32'(4 * $urandom_range(1, 4));
    if (k == 1) return BASE + 32'h1000 + 32'($urandom_range(0, 64));
    return BASE + 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 1) * 4 +
                      (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [31:0] rd;
    int acks;

    repeat (3) @(negedge clk);
    chk("reset_ack", {63'b0, wbs_ack_o}, 64'd0);
    chk("reset_rpatch0", {9'b0, rpatch0}, 64'd0);
    chk("reset_rpatch1", {9'b0, rpatch1}, 64'd0);
    chk("reset_wbs_dat_o", {32'b0, wbs_dat_o}, 64'd0);
    rst_n = 1'b1;
    check_en = 1'b1;

    for (int r = 0; r < DEPTH; r++) begin
      @(negedge clk);
      csb0 = 1'b0; web0 = 1'b0; addr0 = 9'(r);
      wpatch0 = 55'({$urandom(), $urandom()});
    end
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1;

    // accelerator round trip
    acc_cycle(1'b1, 1'b0, 9'd7, ROW7, 1'b0, 9'd0);
    acc_cycle(1'b0, 1'b1, 9'd7, '0, 1'b1, 9'd7);
    chk("acc_rpatch0_row7", {9'b0, rpatch0}, {9'b0, ROW7});
    chk("acc_rpatch1_row7", {9'b0, rpatch1}, {9'b0, ROW7});
    chk("model_r0_row7", {9'b0, exp_r0}, {9'b0, ROW7});

    // byte-masked Wishbone write then chunk-1 read
    @(negedge clk); wb_mode = 1'b1;
    wb_xfer(1'b1, BASE + 32'h38, 32'hAABB_CCDD, 4'b0101, lat, rd);
    chk("wb_write_ack_latency", 64'(lat), 64'd1);
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
    chk("wb_bytemask_row7_lo", {32'b0, rpatch1[31:0]}, 64'h78BB_BCDD);
    wb_xfer(1'b0, BASE + 32'h3C, '0, '0, lat, rd);
    chk("wb_read_ack_latency", 64'(lat), 64'd2);
    chk("wb_read_chunk1", {32'b0, rd}, 64'h0012_3456);
    chk("model_wb_chunk1", {32'b0, exp_dat}, 64'h0012_3456);

    // out-of-window accesses
    wb_miss("miss_above_ack_count", BASE + 32'h1000);
    wb_miss("miss_below_ack_count", BASE - 32'h4);
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
    chk("miss_row7_unchanged", {9'b0, rpatch1}, 64'h0012_3456_78BB_BCDD);

    // same-row collision
    @(negedge clk); wb_mode = 1'b0;
    acc_cycle(1'b1, 1'b0, 9'd3, 55'h5, 1'b0, 9'd0);
    acc_cycle(1'b1, 1'b0, 9'd3, 55'h1, 1'b1, 9'd3);
    chk("collision_old_data", {9'b0, rpatch1}, 64'h5);
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 9'd3);
    chk("collision_new_data", {9'b0, rpatch1}, 64'h1);

    // abort in RD_WAIT
    @(negedge clk); wb_mode = 1'b1;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h18;
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    chk("abort_no_ack", 64'(acks), 64'd0);
    chk("abort_dat_held", {32'b0, wbs_dat_o}, 64'h0012_3456);
    wb_xfer(1'b0, BASE + 32'h18, '0, '0, lat, rd);
    chk("after_abort_latency", 64'(lat), 64'd2);
    chk("after_abort_data", {32'b0, rd}, 64'h1);

    // reset during ACK
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h38; wbs_dat_i = 32'hCAFE_F00D; wbs_sel_i = 4'hF;
    @(posedge clk);
    #2;
    chk("ack_before_reset", {63'b0, wbs_ack_o}, 64'd1);
    rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    #1;
    chk("rst_ack_drop", {63'b0, wbs_ack_o}, 64'd0);
    chk("rst_rpatch0", {9'b0, rpatch0}, 64'd0);
    chk("rst_rpatch1", {9'b0, rpatch1}, 64'd0);
    chk("rst_wbs_dat_o", {32'b0, wbs_dat_o}, 64'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 9'd7);
    chk("rst_mem_retained", {9'b0, rpatch1}, 64'h0012_3456_CAFE_F00D);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) wb_mode = ~wb_mode;
      csb0 = 1'($urandom_range(0, 1)); web0 = 1'($urandom_range(0, 1));
      addr0 = 9'($urandom_range(0, 15)); wpatch0 = 55'({$urandom(), $urandom()});
      csb1 = 1'($urandom_range(0, 1)); addr1 = 9'($urandom_range(0, 15));
      wbs_cyc_i = ($urandom_range(0, 3) != 0); wbs_stb_i = ($urandom_range(0, 3) != 0);
      wbs_we_i = 1'($urandom_range(0, 1)); wbs_sel_i = 4'($urandom_range(0, 15));
      wbs_dat_i = $urandom(); wbs_adr_i = rand_adr();
    end
    @(negedge clk);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
